// File: rtl/ibex_multdiv_arbiter_if.sv
// Requester, response and multdiv-unit signals shared by the arbiter and its neighbours.
// slave: arbiter side. master: requesters plus the multdiv unit.
interface ibex_multdiv_arbiter_if;
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [1:0]  req0_operator_i;
  logic [1:0]  req0_signed_mode_i;
  logic [31:0] req0_op_a_i;
  logic [31:0] req0_op_b_i;
  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [1:0]  req1_operator_i;
  logic [1:0]  req1_signed_mode_i;
  logic [31:0] req1_op_a_i;
  logic [31:0] req1_op_b_i;
  logic        kill0_i;
  logic        kill1_i;
  logic        rsp0_valid_o;
  logic        rsp0_ready_i;
  logic [31:0] rsp0_result_o;
  logic        rsp1_valid_o;
  logic        rsp1_ready_i;
  logic [31:0] rsp1_result_o;
  logic        md_mult_en_o;
  logic        md_div_en_o;
  logic        md_mult_sel_o;
  logic        md_div_sel_o;
  logic [1:0]  md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o;
  logic [31:0] md_op_b_o;
  logic        md_ready_id_o;
  logic        md_valid_i;
  logic [31:0] md_result_i;

  modport slave (
    input  req0_valid_i, req0_operator_i, req0_signed_mode_i, req0_op_a_i, req0_op_b_i,
    output req0_ready_o,
    input  req1_valid_i, req1_operator_i, req1_signed_mode_i, req1_op_a_i, req1_op_b_i,
    output req1_ready_o,
    input  kill0_i, kill1_i,
    output rsp0_valid_o, rsp0_result_o,
    input  rsp0_ready_i,
    output rsp1_valid_o, rsp1_result_o,
    input  rsp1_ready_i,
    output md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o,
    output md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o, md_ready_id_o,
    input  md_valid_i, md_result_i
  );

  modport master (
    output req0_valid_i, req0_operator_i, req0_signed_mode_i, req0_op_a_i, req0_op_b_i,
    input  req0_ready_o,
    output req1_valid_i, req1_operator_i, req1_signed_mode_i, req1_op_a_i, req1_op_b_i,
    input  req1_ready_o,
    output kill0_i, kill1_i,
    input  rsp0_valid_o, rsp0_result_o,
    output rsp0_ready_i,
    input  rsp1_valid_o, rsp1_result_o,
    output rsp1_ready_i,
    input  md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o,
    input  md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o, md_ready_id_o,
    output md_valid_i, md_result_i
  );
endinterface

// File: rtl/ibex_multdiv_arbiter.sv
// Round-robin sharing of one multdiv unit between two requesters, with one-entry result slots.
// Latency: accept at T drives unit enables from T+1; unit valid at V gives response valid at V+1.
// Backpressure: a full result slot stalls only its own requester; kills drain the unit silently.
module ibex_multdiv_arbiter #(
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ibex_multdiv_arbiter_if.slave bus,
  output logic                  err_o
);
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYCLES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [1:0]    op_q, op_d;
  logic [1:0]    sm_q, sm_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [1:0]    rsp_vld_q, rsp_vld_d;
  logic [31:0]   rsp0_res_q, rsp0_res_d;
  logic [31:0]   rsp1_res_q, rsp1_res_d;

  logic elig0, elig1, grant, accept, busy, kill_own;

  assign elig0  = bus.req0_valid_i & ~rsp_vld_q[0];
  assign elig1  = bus.req1_valid_i & ~rsp_vld_q[1];
  assign busy   = (state_q == BUSY);
  assign accept = ~busy & (elig0 | elig1);

  // Contention goes to whoever was not granted last; otherwise the lone eligible requester.
  assign grant  = (elig0 & elig1) ? ~last_grant_q : elig1;

  assign kill_own = busy & (owner_q ? bus.kill1_i : bus.kill0_i);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    kill_d       = kill_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    sm_d         = sm_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_vld_d    = rsp_vld_q;
    rsp0_res_d   = rsp0_res_q;
    rsp1_res_d   = rsp1_res_q;

    if (rsp_vld_q[0] && bus.rsp0_ready_i) rsp_vld_d[0] = 1'b0;
    if (rsp_vld_q[1] && bus.rsp1_ready_i) rsp_vld_d[1] = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = BUSY;
          owner_d      = grant;
          last_grant_d = grant;
          kill_d       = 1'b0;
          cnt_d        = '0;
          op_d         = grant ? bus.req1_operator_i    : bus.req0_operator_i;
          sm_d         = grant ? bus.req1_signed_mode_i : bus.req0_signed_mode_i;
          a_d          = grant ? bus.req1_op_a_i        : bus.req0_op_a_i;
          b_d          = grant ? bus.req1_op_b_i        : bus.req0_op_b_i;
        end
      end
      BUSY: begin
        if (kill_own) kill_d = 1'b1;
        if (bus.md_valid_i) begin
          state_d = IDLE;
          // A kill landing in the completion cycle still discards the result.
          if (!(kill_q || kill_own)) begin
            rsp_vld_d[owner_q] = 1'b1;
            if (owner_q) rsp1_res_d = bus.md_result_i;
            else         rsp0_res_d = bus.md_result_i;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_d = err_q | (cnt_d == CNT_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      kill_q       <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      op_q         <= '0;
      sm_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_vld_q    <= '0;
      rsp0_res_q   <= '0;
      rsp1_res_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      kill_q       <= kill_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      op_q         <= op_d;
      sm_q         <= sm_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp0_res_q   <= rsp0_res_d;
      rsp1_res_q   <= rsp1_res_d;
    end
  end

  assign bus.req0_ready_o     = accept & ~grant;
  assign bus.req1_ready_o     = accept & grant;
  assign bus.rsp0_valid_o     = rsp_vld_q[0];
  assign bus.rsp1_valid_o     = rsp_vld_q[1];
  assign bus.rsp0_result_o    = rsp0_res_q;
  assign bus.rsp1_result_o    = rsp1_res_q;
  assign bus.md_mult_en_o     = busy & ~op_q[1];
  assign bus.md_mult_sel_o    = busy & ~op_q[1];
  assign bus.md_div_en_o      = busy & op_q[1];
  assign bus.md_div_sel_o     = busy & op_q[1];
  assign bus.md_operator_o    = op_q;
  assign bus.md_signed_mode_o = sm_q;
  assign bus.md_op_a_o        = a_q;
  assign bus.md_op_b_o        = b_q;
  assign bus.md_ready_id_o    = busy & bus.md_valid_i;
  assign err_o                = err_q;
endmodule
